silife_max7219_ctrl: RTL and testbench

Display sequencer that drives a daisy-chain of MAX7219 8x8 LED modules over a 3-wire SPI bus (cs/sck/mosi) from the Game-of-Life cell array. On enable it sends the MAX7219 init sequence. On each refresh request it fetches the 8 grid rows through a read handshake and shifts one digit-register transaction per row. It owns the SPI pins in the wrapper, and manages brightness updates and shutdown when disabled.

---
 rtl/silife_max7219_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_silife_max7219_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_max7219_ctrl.sv
// MAX7219 daisy-chain display sequencer: init broadcast, per-frame row refresh,
// brightness updates and shutdown, bit-banged over a 3-wire SPI bus.
module silife_max7219_ctrl #(
  parameter int CHAIN   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [3:0]         i_brightness,
  input  logic               i_refresh_req,
  output logic [2:0]         o_row_addr,
  output logic               o_row_rd,
  input  logic [8*CHAIN-1:0] i_row_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_spi_cs,
  output logic               o_spi_sck,
  output logic               o_spi_mosi
);

  // state      | meaning
  // S_IDLE     | waiting; armed after init, disarmed after shutdown/reset
  // S_INIT     | load next init broadcast word
  // S_FETCH    | row read strobe, capture row data one cycle later
  // S_SHIFT    | one cs-framed transaction on the SPI pins
  // S_GAP      | minimum cs-high time, then choose next transaction
  // S_SHUTDOWN | load the shutdown broadcast word

  localparam int NBITS = 16 * CHAIN;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(2 * CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LD = BIT_W'(NBITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FETCH, S_SHIFT, S_GAP, S_SHUTDOWN} state_t;
  typedef enum logic [2:0] {PH_START, PH_SETUP, PH_HIGH, PH_LOW, PH_HOLD} phase_t;
  typedef enum logic [1:0] {J_INIT, J_BRI, J_ROW, J_SHDN} job_t;

  state_t           r_state;
  phase_t           r_phase;
  job_t             r_job;
  logic [2:0]       r_init_idx;
  logic [DIV_W-1:0] r_div;
  logic [GAP_W-1:0] r_gap;
  logic [BIT_W-1:0] r_bit;
  logic [NBITS-1:0] r_shreg;
  logic             r_fetch_wait;
  logic             r_pending;
  logic             r_armed;
  logic [3:0]       r_sent_bri;
  logic [2:0]       r_row_addr;
  logic             r_row_rd;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_spi_cs;
  logic             r_spi_sck;
  logic             r_spi_mosi;

  function automatic logic [NBITS-1:0] f_bcast(input logic [3:0] addr, input logic [7:0] data);
    return {CHAIN{4'h0, addr, data}};
  endfunction

  // Module k occupies bits [16k+15:16k]; the top word is shifted out first.
  function automatic logic [NBITS-1:0] f_row_word(input logic [2:0] row,
                                                  input logic [8*CHAIN-1:0] cells);
    logic [NBITS-1:0] w;
    w = '0;
    for (int k = 0; k < CHAIN; k++) begin
      w[16*k +: 16] = {4'h0, {1'b0, row} + 4'd1, cells[8*k +: 8]};
    end
    return w;
  endfunction

  function automatic logic [NBITS-1:0] f_init_word(input logic [2:0] idx, input logic [3:0] bri);
    logic [NBITS-1:0] w;
    case (idx)
      3'd0:    w = f_bcast(4'hF, 8'h00);
      3'd1:    w = f_bcast(4'hB, 8'h07);
      3'd2:    w = f_bcast(4'h9, 8'h00);
      3'd3:    w = f_bcast(4'hA, {4'h0, bri});
      default: w = f_bcast(4'hC, 8'h01);
    endcase
    return w;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_START;
      r_job        <= J_INIT;
      r_init_idx   <= '0;
      r_div        <= '0;
      r_gap        <= '0;
      r_bit        <= '0;
      r_shreg      <= '0;
      r_fetch_wait <= 1'b0;
      r_pending    <= 1'b0;
      r_armed      <= 1'b0;
      r_sent_bri   <= '0;
      r_row_addr   <= '0;
      r_row_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_spi_cs     <= 1'b1;
      r_spi_sck    <= 1'b0;
      r_spi_mosi   <= 1'b0;
    end else begin
      r_row_rd     <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_refresh_req && r_state != S_IDLE) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (!r_armed && i_en) begin
            r_init_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_INIT;
          end else if (r_armed && !i_en) begin
            r_busy  <= 1'b1;
            r_state <= S_SHUTDOWN;
          end else if (r_armed && (i_refresh_req || r_pending)) begin
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            if (i_brightness != r_sent_bri) begin
              r_shreg    <= f_bcast(4'hA, {4'h0, i_brightness});
              r_sent_bri <= i_brightness;
              r_job      <= J_BRI;
              r_state    <= S_SHIFT;
            end else begin
              r_row_addr   <= '0;
              r_row_rd     <= 1'b1;
              r_fetch_wait <= 1'b0;
              r_state      <= S_FETCH;
            end
          end
        end

        S_INIT: begin
          r_shreg <= f_init_word(r_init_idx, i_brightness);
          if (r_init_idx == 3'd3) r_sent_bri <= i_brightness;
          r_job   <= J_INIT;
          r_state <= S_SHIFT;
        end

        S_SHUTDOWN: begin
          r_shreg   <= f_bcast(4'hC, 8'h00);
          r_job     <= J_SHDN;
          r_pending <= 1'b0;
          r_state   <= S_SHIFT;
        end

        S_FETCH: begin
          if (!i_en) begin
            r_state <= S_SHUTDOWN;
          end else if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_shreg <= f_row_word(r_row_addr, i_row_data);
            r_job   <= J_ROW;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_phase != PH_START && r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            case (r_phase)
              PH_START: begin
                r_spi_cs   <= 1'b0;
                r_spi_mosi <= r_shreg[NBITS-1];
                r_div      <= DIV_LD;
                r_bit      <= BIT_LD;
                r_phase    <= PH_SETUP;
              end
              PH_SETUP: begin
                r_spi_sck <= 1'b1;
                r_div     <= DIV_LD;
                r_phase   <= PH_HIGH;
              end
              // Data only moves on the falling sck edge.
              PH_HIGH: begin
                r_spi_sck  <= 1'b0;
                r_spi_mosi <= r_shreg[NBITS-2];
                r_shreg    <= {r_shreg[NBITS-2:0], 1'b0};
                r_div      <= DIV_LD;
                r_phase    <= PH_LOW;
              end
              PH_LOW: begin
                r_div <= DIV_LD;
                if (r_bit == '0) begin
                  r_phase <= PH_HOLD;
                end else begin
                  r_spi_sck <= 1'b1;
                  r_bit     <= r_bit - 1'b1;
                  r_phase   <= PH_HIGH;
                end
              end
              PH_HOLD: begin
                r_spi_cs <= 1'b1;
                r_gap    <= GAP_LD;
                r_phase  <= PH_START;
                r_state  <= S_GAP;
              end
              default: r_phase <= PH_START;
            endcase
          end
        end

        S_GAP: begin
          if (r_gap == GAP_LD && r_job == J_ROW && r_row_addr == 3'd7 && i_en)
            r_frame_done <= 1'b1;
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (r_job == J_SHDN) begin
            r_armed   <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end else if (!i_en) begin
            r_state <= S_SHUTDOWN;
          end else begin
            case (r_job)
              J_INIT: begin
                if (r_init_idx == 3'd4) begin
                  r_armed <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end else begin
                  r_init_idx <= r_init_idx + 3'd1;
                  r_state    <= S_INIT;
                end
              end
              J_BRI: begin
                r_row_addr   <= '0;
                r_row_rd     <= 1'b1;
                r_fetch_wait <= 1'b0;
                r_state      <= S_FETCH;
              end
              default: begin
                if (r_row_addr == 3'd7) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end else begin
                  r_row_addr   <= r_row_addr + 3'd1;
                  r_row_rd     <= 1'b1;
                  r_fetch_wait <= 1'b0;
                  r_state      <= S_FETCH;
                end
              end
            endcase
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_row_addr   = r_row_addr;
  assign o_row_rd     = r_row_rd;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_spi_cs     = r_spi_cs;
  assign o_spi_sck    = r_spi_sck;
  assign o_spi_mosi   = r_spi_mosi;

endmodule

// File: tb/tb_silife_max7219_ctrl.sv
// Bench for silife_max7219_ctrl: SPI decoder plus a transaction-level
// reference model of the init/frame/brightness/shutdown word stream.
module tb_silife_max7219_ctrl;
  localparam int CH     = 2;
  localparam int DIV    = 2;
  localparam int GW     = 8 * CH;
  localparam int NB     = 16 * CH;
  localparam int LOWLEN = DIV * (32 * CH + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    bri = 4'd5;
  logic          req = 1'b0;
  logic [2:0]    row_addr;
  logic          row_rd;
  logic [GW-1:0] row_data = '0;
  logic          busy, fd, cs, sck, mosi;

  always #5 clk = ~clk;

  silife_max7219_ctrl #(.CHAIN(CH), .CLK_DIV(DIV)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_brightness(bri),
    .i_refresh_req(req), .o_row_addr(row_addr), .o_row_rd(row_rd),
    .i_row_data(row_data), .o_busy(busy), .o_frame_done(fd),
    .o_spi_cs(cs), .o_spi_sck(sck), .o_spi_mosi(mosi)
  );

  int total = 0;
  int bad = 0;

  logic [GW-1:0] grid [8];
  logic [63:0]   exp_w[$], cap_w[$];
  int            cap_len[$], cap_bits[$], exp_r[$], cap_r[$];
  int            fd_cnt = 0, exp_fd = 0;
  int            viol_mosi = 0, viol_rd = 0, viol_fd = 0, min_gap = 1000000;
  int            cyc = 0, lowc = 0, bitc = 0, gapc = 0, last_rise = 0;
  logic [63:0]   sh = '0;
  logic          p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_rd = 1'b0, seen_tx = 1'b0;
  logic          pend = 1'b0;
  logic [2:0]    pend_addr = '0;
  logic [3:0]    m_sent = '0;

  // SPI/row-port observer and the row memory responder (data valid one cycle after the strobe).
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      p_cs = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; p_rd = 1'b0; seen_tx = 1'b0; pend = 1'b0;
    end else begin
      if (p_cs && !cs) begin
        lowc = 1; bitc = 0; sh = '0;
        if (seen_tx && gapc < min_gap) min_gap = gapc;
      end else if (!cs) lowc++;
      if (!cs && sck && !p_sck) begin sh = {sh[62:0], mosi}; bitc++; end
      if (!p_cs && !cs && mosi !== p_mosi && !(p_sck && !sck)) viol_mosi++;
      if (!p_cs && cs) begin
        cap_w.push_back(sh); cap_len.push_back(lowc); cap_bits.push_back(bitc);
        gapc = 1; seen_tx = 1'b1; last_rise = cyc;
      end else if (cs) gapc++;
      if (row_rd && p_rd) viol_rd++;
      if (row_rd) cap_r.push_back(int'(row_addr));
      if (fd) begin fd_cnt++; if (cyc - last_rise != 1) viol_fd++; end
      if (pend) begin row_data = grid[pend_addr]; pend = 1'b0; end
      if (row_rd) begin pend = 1'b1; pend_addr = row_addr; row_data = GW'($urandom); end
      p_cs = cs; p_sck = sck; p_mosi = mosi; p_rd = row_rd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] bcast(input int a, input int d);
    logic [63:0] w = '0;
    for (int k = 0; k < CH; k++) w = (w << 16) | 64'(a * 256 + d);
    return w;
  endfunction

  function automatic logic [63:0] roww(input int r);
    logic [63:0]   w = '0;
    logic [GW-1:0] t;
    for (int k = CH - 1; k >= 0; k--) begin
      t = grid[r] >> (8 * k);
      w = (w << 16) | 64'((r + 1) * 256 + int'(t[7:0]));
    end
    return w;
  endfunction

  task automatic model_init();
    exp_w.push_back(bcast(15, 0));
    exp_w.push_back(bcast(11, 7));
    exp_w.push_back(bcast(9, 0));
    exp_w.push_back(bcast(10, int'(bri)));
    exp_w.push_back(bcast(12, 1));
    m_sent = bri;
  endtask

  task automatic model_frame(input int nrows, input bit full);
    if (bri != m_sent) begin exp_w.push_back(bcast(10, int'(bri))); m_sent = bri; end
    for (int r = 0; r < nrows; r++) begin exp_w.push_back(roww(r)); exp_r.push_back(r); end
    if (full) exp_fd++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    req = 1'b1; @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0, n = 0;
    while (q < 12 && n < budget) begin
      @(negedge clk); n++;
      q = busy ? 0 : q + 1;
    end
    chk({tag, "_settled"}, 64'(n < budget), 64'd1);
  endtask

  task automatic compare_tx(input string tag);
    int n;
    chk({tag, "_ntx"}, 64'(cap_w.size()), 64'(exp_w.size()));
    n = (cap_w.size() < exp_w.size()) ? cap_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", tag, i), cap_w[i], exp_w[i]);
      chk($sformatf("%s_cslow%0d", tag, i), 64'(cap_len[i]), 64'(LOWLEN));
      chk($sformatf("%s_bits%0d", tag, i), 64'(cap_bits[i]), 64'(NB));
    end
    chk({tag, "_nrows"}, 64'(cap_r.size()), 64'(exp_r.size()));
    n = (cap_r.size() < exp_r.size()) ? cap_r.size() : exp_r.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_row%0d", tag, i), 64'(cap_r[i]), 64'(exp_r[i]));
    chk({tag, "_frame_done"}, 64'(fd_cnt), 64'(exp_fd));
    cap_w.delete(); cap_len.delete(); cap_bits.delete(); cap_r.delete();
    exp_w.delete(); exp_r.delete();
  endtask

  task automatic random_grid();
    for (int r = 0; r < 8; r++) grid[r] = GW'($urandom);
  endtask

  initial begin
    int n;
    for (int r = 0; r < 8; r++) grid[r] = '0;
    tick(3);
    chk("rst_cs", 64'(cs), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_row_rd", 64'(row_rd), 64'd0);
    chk("rst_row_addr", 64'(row_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(fd), 64'd0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_disabled_busy", 64'(busy), 64'd0);
    chk("idle_disabled_tx", 64'(cap_w.size()), 64'd0);

    en = 1'b1;
    model_init();
    wait_quiet("init", 5000);
    compare_tx("init");

    for (int r = 0; r < 8; r++)
      for (int k = 0; k < CH; k++)
        grid[r][8*k +: 8] = (k % 2 == 0) ? (8'h80 >> r) : (8'h01 << r);
    pulse_req();
    chk("frame_busy", 64'(busy), 64'd1);
    model_frame(8, 1'b1);
    wait_quiet("walk", 6000);
    compare_tx("walk");

    random_grid();
    grid[0] = GW'(16'hA55A);
    pulse_req();
    model_frame(8, 1'b1);
    wait_quiet("a55a", 6000);
    chk("a55a_first", (cap_w.size() > 0) ? cap_w[0] : 64'hDEAD, 64'h01A5015A);
    compare_tx("a55a");

    bri = 4'hF;
    random_grid();
    pulse_req();
    model_frame(8, 1'b1);
    wait_quiet("bri", 6000);
    chk("bri_first", (cap_w.size() > 0) ? cap_w[0] : 64'hDEAD, 64'h0A0F0A0F);
    compare_tx("bri");
    pulse_req();
    model_frame(8, 1'b1);
    wait_quiet("nobri", 6000);
    compare_tx("nobri");

    for (int i = 0; i < 3; i++) begin
      random_grid();
      bri = 4'($urandom_range(0, 15));
      pulse_req();
      model_frame(8, 1'b1);
      wait_quiet($sformatf("rnd%0d", i), 6000);
      compare_tx($sformatf("rnd%0d", i));
    end

    random_grid();
    pulse_req();
    model_frame(8, 1'b1);
    tick(50);
    for (int i = 0; i < 3; i++) begin pulse_req(); tick(20); end
    model_frame(8, 1'b1);
    wait_quiet("pend", 12000);
    compare_tx("pend");

    random_grid();
    pulse_req();
    model_frame(4, 1'b0);
    exp_w.push_back(bcast(12, 0));
    n = 0;
    while (!(row_addr == 3'd3 && cs == 1'b0) && n < 4000) begin @(negedge clk); n++; end
    chk("row3_seen", 64'(n < 4000), 64'd1);
    en = 1'b0;
    wait_quiet("endrop", 4000);
    chk("endrop_busy", 64'(busy), 64'd0);
    compare_tx("endrop");

    bri = 4'($urandom_range(0, 15));
    en = 1'b1;
    model_init();
    wait_quiet("reinit", 5000);
    compare_tx("reinit");

    random_grid();
    pulse_req();
    model_frame(8, 1'b1);
    wait_quiet("last", 6000);
    compare_tx("last");

    chk("mosi_stable", 64'(viol_mosi), 64'd0);
    chk("row_rd_single", 64'(viol_rd), 64'd0);
    chk("frame_done_timing", 64'(viol_fd), 64'd0);
    chk("min_gap_ok", 64'(min_gap >= 2 * DIV), 64'd1);

    pulse_req();
    n = 0;
    while (cs == 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("midtx_cs_low", 64'(cs), 64'd0);
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs", 64'(cs), 64'd1);
    chk("async_rst_sck", 64'(sck), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_row_addr", 64'(row_addr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
